// File: rtl/pr_bus_pkg.sv
// Shared types and constants for the processor-side device bus.
package pr_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Default device windows, also used by the timer bridge and the MEM-stage range compare
  localparam logic [31:0] DEF_T0_BASE   = 32'h0000_7F00;
  localparam logic [31:0] DEF_T1_BASE   = 32'h0000_7F10;
  localparam int          DEF_WIN_BYTES = 12;

  localparam int CNT_W = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pr_addr_decode.sv
// Combinational Timer0/Timer1 window decode. Misaligned or out-of-window
// addresses report err; if windows ever overlap, dev0 takes priority.
module pr_addr_decode import pr_bus_pkg::*; #(
  parameter logic [31:0] T0_BASE   = DEF_T0_BASE,
  parameter logic [31:0] T1_BASE   = DEF_T1_BASE,
  parameter int          WIN_BYTES = DEF_WIN_BYTES
) (
  input  logic [31:0] addr,
  output logic        sel0,
  output logic        sel1,
  output logic        err
);

  // 33-bit compares so a window near the top of the map cannot wrap
  localparam logic [32:0] T0_LO = {1'b0, T0_BASE};
  localparam logic [32:0] T1_LO = {1'b0, T1_BASE};
  localparam logic [32:0] T0_HI = T0_LO + 33'(WIN_BYTES);
  localparam logic [32:0] T1_HI = T1_LO + 33'(WIN_BYTES);

  logic [32:0] addr_x;
  logic        aligned;
  logic        in_t0;
  logic        in_t1;

  assign addr_x  = {1'b0, addr};
  assign aligned = (addr[1:0] == 2'b00);
  assign in_t0   = (addr_x >= T0_LO) && (addr_x < T0_HI);
  assign in_t1   = (addr_x >= T1_LO) && (addr_x < T1_HI);

  assign sel0 = aligned & in_t0;
  assign sel1 = aligned & in_t1 & ~in_t0;
  assign err  = ~(sel0 | sel1);

endmodule

// File: rtl/pr_bus_arbiter.sv
// Two-master (CPU / DMA) arbiter and fixed-latency access sequencer for the
// Timer0/Timer1 register windows.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | arbitrate; decode errors jump straight to ST_RESP
//   ST_ACCESS | counter runs WAIT_CYCLES..1; strobe/capture when it is 1
//   ST_RESP   | one-cycle done pulse to the owner, then back to ST_IDLE
module pr_bus_arbiter import pr_bus_pkg::*; #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] T0_BASE     = DEF_T0_BASE,
  parameter logic [31:0] T1_BASE     = DEF_T1_BASE,
  parameter int          WIN_BYTES   = DEF_WIN_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_kill,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_done,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wd,
  output logic        dev_we0,
  output logic        dev_we1,
  input  logic [31:0] dev_rd0,
  input  logic [31:0] dev_rd1
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_grant;
  logic             we_q;
  logic [31:0]      addr_q;

  logic        cpu_valid;
  logic        dma_valid;
  logic        grant;
  logic        win;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [31:0] dec_addr;
  logic        sel0;
  logic        sel1;
  logic        dec_err;
  logic [31:0] rd_mux;

  assign cpu_valid = cpu_req & ~cpu_kill;
  assign dma_valid = dma_req;
  assign grant     = (state == ST_IDLE) & (cpu_valid | dma_valid);
  assign cpu_stall = cpu_req & ~cpu_kill & ~cpu_done;

  // Round-robin pick: on a tie the master not granted last time wins
  always_comb begin
    win = OWN_CPU;
    if (cpu_valid && dma_valid) win = (last_grant == OWN_DMA) ? OWN_CPU : OWN_DMA;
    else if (dma_valid)         win = OWN_DMA;
  end

  assign win_we    = (win == OWN_DMA) ? dma_we    : cpu_we;
  assign win_addr  = (win == OWN_DMA) ? dma_addr  : cpu_addr;
  assign win_wdata = (win == OWN_DMA) ? dma_wdata : cpu_wdata;

  // In IDLE the decode must see the incoming address so an error can skip ACCESS
  assign dec_addr = (state == ST_IDLE) ? win_addr : addr_q;
  assign rd_mux   = sel1 ? dev_rd1 : dev_rd0;

  pr_addr_decode #(
    .T0_BASE   (T0_BASE),
    .T1_BASE   (T1_BASE),
    .WIN_BYTES (WIN_BYTES)
  ) u_decode (
    .addr (dec_addr),
    .sel0 (sel0),
    .sel1 (sel1),
    .err  (dec_err)
  );

  // Access sequencer; strobes are registered so they land on the counter==1 cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      owner      <= OWN_CPU;
      last_grant <= OWN_DMA;
      we_q       <= 1'b0;
      addr_q     <= '0;
      dev_addr   <= '0;
      dev_wd     <= '0;
      dev_we0    <= 1'b0;
      dev_we1    <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      dma_done   <= 1'b0;
      dma_err    <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dev_we0  <= 1'b0;
      dev_we1  <= 1'b0;
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner      <= win;
            last_grant <= win;
            we_q       <= win_we;
            addr_q     <= win_addr;
            dev_addr   <= word_align(win_addr);
            dev_wd     <= win_wdata;
            if (dec_err) begin
              state <= ST_RESP;
              cnt   <= '0;
              if (win == OWN_CPU) begin
                cpu_done  <= 1'b1;
                cpu_err   <= 1'b1;
                cpu_rdata <= '0;
              end else begin
                dma_done  <= 1'b1;
                dma_err   <= 1'b1;
                dma_rdata <= '0;
              end
            end else begin
              state <= ST_ACCESS;
              cnt   <= CNT_LOAD;
              if (WAIT_CYCLES == 1) begin
                dev_we0 <= win_we & sel0;
                dev_we1 <= win_we & sel1;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_RESP;
            cnt   <= '0;
            if (owner == OWN_CPU) begin
              cpu_done <= 1'b1;
              cpu_err  <= 1'b0;
              if (!we_q) cpu_rdata <= rd_mux;
            end else begin
              dma_done <= 1'b1;
              dma_err  <= 1'b0;
              if (!we_q) dma_rdata <= rd_mux;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(2)) begin
              dev_we0 <= we_q & sel0;
              dev_we1 <= we_q & sel1;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Bench for pr_bus_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
// A second instance with WAIT_CYCLES=3 exercises reset during ACCESS.
module tb_pr_bus_arbiter;

  localparam int W  = 1;
  localparam int W3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rst3;
  logic        cpu_req, cpu_we, cpu_kill;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [31:0] dev_rd0, dev_rd1;

  logic        cpu_stall, cpu_done, cpu_err, dma_done, dma_err, dev_we0, dev_we1;
  logic [31:0] cpu_rdata, dma_rdata, dev_addr, dev_wd;
  logic        b_cpu_stall, b_cpu_done, b_cpu_err, b_dma_done, b_dma_err, b_dev_we0, b_dev_we1;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_dev_addr, b_dev_wd;

  pr_bus_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_kill(cpu_kill), .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(dma_done), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_we0(dev_we0), .dev_we1(dev_we1),
    .dev_rd0(dev_rd0), .dev_rd1(dev_rd1)
  );

  pr_bus_arbiter #(.WAIT_CYCLES(W3)) u_dut3 (
    .clk(clk), .reset(rst3),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_kill(cpu_kill), .cpu_stall(b_cpu_stall), .cpu_done(b_cpu_done), .cpu_err(b_cpu_err),
    .cpu_rdata(b_cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(b_dma_done), .dma_err(b_dma_err), .dma_rdata(b_dma_rdata),
    .dev_addr(b_dev_addr), .dev_wd(b_dev_wd), .dev_we0(b_dev_we0), .dev_we1(b_dev_we1),
    .dev_rd0(dev_rd0), .dev_rd1(dev_rd1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // 0 = Timer0, 1 = Timer1, 2 = bus error
  function automatic int decode(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2;
    if (a >= 32'h7F00 && a < 32'h7F0C) return 0;
    if (a >= 32'h7F10 && a < 32'h7F1C) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0:       a = 32'h7F00 + 4 * $urandom_range(0, 3);
      1:       a = 32'h7F10 + 4 * $urandom_range(0, 3);
      2:       a = 32'h7F00 + $urandom_range(0, 31);
      3:       a = 32'h7EFC;
      4:       a = 32'h7F20;
      default: a = $urandom;
    endcase
    return a;
  endfunction

  // Reference model: one transfer in flight, tracked by phase = cycles since grant.
  // Transfer length is 1 for a decode error, W+1 otherwise; done on the last phase.
  bit          m_busy, m_own, m_we, m_err, m_sel, m_last;
  int          m_ph;
  logic [31:0] m_addr, m_wd, m_crd, m_drd;
  bit          m_cerr, m_derr;
  bit          e_cdone, e_ddone;

  always @(negedge clk) begin : model
    int len;
    bit cv, dv, acc;
    int dc;
    if (!reset) begin
      m_busy = 0; m_last = 1; m_ph = 0; m_crd = '0; m_drd = '0;
      m_cerr = 0; m_derr = 0; e_cdone = 0; e_ddone = 0;
    end else begin
      len     = m_err ? 1 : W + 1;
      e_cdone = m_busy && m_ph == len && !m_own;
      e_ddone = m_busy && m_ph == len && m_own;
      acc     = m_busy && !m_err && m_ph <= W;
      chk("cpu_done", cpu_done, e_cdone);
      chk("dma_done", dma_done, e_ddone);
      chk("dev_we0", dev_we0, acc && m_we && m_ph == W && !m_sel);
      chk("dev_we1", dev_we1, acc && m_we && m_ph == W && m_sel);
      chk("cpu_stall", cpu_stall, cpu_req & ~cpu_kill & ~e_cdone);
      chk("cpu_rdata", cpu_rdata, m_crd);
      chk("dma_rdata", dma_rdata, m_drd);
      if (e_cdone) chk("cpu_err", cpu_err, m_cerr);
      if (e_ddone) chk("dma_err", dma_err, m_derr);
      if (acc) begin
        chk("dev_addr", dev_addr, {m_addr[31:2], 2'b00});
        chk("dev_wd", dev_wd, m_wd);
      end
      if (m_busy) begin
        if (m_ph == len) m_busy = 0;
        else begin
          if (m_ph == W) begin
            if (!m_own) begin m_cerr = 0; if (!m_we) m_crd = m_sel ? dev_rd1 : dev_rd0; end
            else        begin m_derr = 0; if (!m_we) m_drd = m_sel ? dev_rd1 : dev_rd0; end
          end
          m_ph++;
        end
      end else begin
        cv = cpu_req & ~cpu_kill;
        dv = dma_req;
        if (cv || dv) begin
          m_own  = (cv && dv) ? ~m_last : dv;
          m_last = m_own;
          m_we   = m_own ? dma_we : cpu_we;
          m_addr = m_own ? dma_addr : cpu_addr;
          m_wd   = m_own ? dma_wdata : cpu_wdata;
          dc     = decode(m_addr);
          m_err  = (dc == 2);
          m_sel  = (dc == 1);
          m_busy = 1;
          m_ph   = 1;
          if (m_err) begin
            if (!m_own) begin m_cerr = 1; m_crd = '0; end
            else        begin m_derr = 1; m_drd = '0; end
          end
        end
      end
    end
  end

  task automatic cpu_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output int n_stall, output int n_we0, output int n_we1,
                            output logic [31:0] s_addr, output logic [31:0] s_wd);
    bit fin;
    lat = 0; n_stall = 0; n_we0 = 0; n_we1 = 0; s_addr = '0; s_wd = '0; fin = 0;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int c = 1; c <= 20 && !fin; c++) begin
      @(negedge clk);
      if (cpu_stall) n_stall++;
      if (dev_we0) begin n_we0++; s_addr = dev_addr; s_wd = dev_wd; end
      if (dev_we1) begin n_we1++; s_addr = dev_addr; s_wd = dev_wd; end
      if (cpu_done) begin fin = 1; lat = c; end
      @(posedge clk); #1;
    end
    cpu_req = 0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, ns, n0, n1, nd, seen_stall, seen_cdone, got;
    logic [31:0] sa, sw;
    reset = 0; rst3 = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_kill = 0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    dev_rd0 = '0; dev_rd1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {cpu_done, dma_done, cpu_err, dma_err, dev_we0, dev_we1}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_dev_addr", dev_addr, 0);
    chk("rst_dev_wd", dev_wd, 0);
    @(posedge clk); #1 reset = 1; rst3 = 1;
    @(posedge clk); #1;

    // CPU load from Timer0
    dev_rd0 = 32'hA5A5_0001;
    cpu_access(0, 32'h7F04, 32'h0, lat, ns, n0, n1, sa, sw);
    chk("load_latency", lat, 3);
    chk("load_stall_cycles", ns, 2);
    chk("load_strobes", n0 + n1, 0);
    chk("load_rdata", cpu_rdata, 32'hA5A5_0001);

    // CPU store to Timer1
    cpu_access(1, 32'h7F10, 32'h1234, lat, ns, n0, n1, sa, sw);
    chk("store_latency", lat, 3);
    chk("store_we1_count", n1, 1);
    chk("store_we0_count", n0, 0);
    chk("store_dev_addr", sa, 32'h7F10);
    chk("store_dev_wd", sw, 32'h1234);
    chk("store_err", cpu_err, 0);

    // Decode errors: out of window, then misaligned
    cpu_access(1, 32'h7F20, 32'h55, lat, ns, n0, n1, sa, sw);
    chk("err_oow_latency", lat, 2);
    chk("err_oow_err", cpu_err, 1);
    chk("err_oow_strobes", n0 + n1, 0);
    cpu_access(1, 32'h7F02, 32'h66, lat, ns, n0, n1, sa, sw);
    chk("err_mis_latency", lat, 2);
    chk("err_mis_err", cpu_err, 1);
    chk("err_mis_strobes", n0 + n1, 0);
    chk("err_mis_rdata", cpu_rdata, 0);

    // Both masters request continuously from reset
    reset = 0; rst3 = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h7F00; dma_req = 1; dma_we = 0; dma_addr = 32'h7F14;
    @(posedge clk); #1 reset = 1; rst3 = 1;
    nd = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cpu_done || dma_done) begin
        chk("rr_done_cycle", c, 3 * (nd + 1));
        chk("rr_owner_is_dma", dma_done, nd % 2);
        nd++;
      end
      @(posedge clk); #1;
    end
    chk("rr_done_count", nd, 4);
    cpu_req = 0; dma_req = 0;
    @(posedge clk); #1;

    // Killed CPU request with DMA pending; last grant was DMA
    cpu_req = 1; cpu_kill = 1; cpu_we = 1; cpu_addr = 32'h7F00;
    dma_req = 1; dma_we = 0; dma_addr = 32'h7F18;
    got = 0; seen_stall = 0; seen_cdone = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (cpu_stall) seen_stall++;
      if (cpu_done) seen_cdone++;
      if (dma_done && got == 0) got = c;
      @(posedge clk); #1;
      if (got != 0) dma_req = 0;
    end
    chk("kill_dma_done_cycle", got, 3);
    chk("kill_cpu_done", seen_cdone, 0);
    chk("kill_stall", seen_stall, 0);
    cpu_req = 0; cpu_kill = 0;

    // Reset during ACCESS of a write on the WAIT_CYCLES=3 instance
    repeat (10) begin @(posedge clk); #1; end
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h7F00; cpu_wdata = 32'hCAFE; dma_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 0; cpu_req = 0;
    n0 = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (b_dev_we0 || b_dev_we1) n0++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst3_strobes", n0, 0);
    chk("rst3_flags", {b_cpu_stall, b_cpu_done, b_cpu_err, b_dma_done, b_dma_err, b_dev_we0, b_dev_we1}, 0);
    chk("rst3_rdata", b_cpu_rdata | b_dma_rdata, 0);
    chk("rst3_dev", b_dev_addr | b_dev_wd, 0);
    @(posedge clk); #1;
    rst3 = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h7F08; dma_req = 1; dma_we = 0; dma_addr = 32'h7F18;
    got = 0; nd = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (got == 0 && b_cpu_done) got = c;
      if (got == 0 && b_dma_done) nd = c;
      @(posedge clk); #1;
      if (got != 0 || nd != 0) begin cpu_req = 0; dma_req = 0; end
    end
    chk("rst3_first_cpu_cycle", got, W3 + 2);
    chk("rst3_dma_not_first", nd, 0);
    cpu_req = 0; dma_req = 0;
    repeat (8) begin @(posedge clk); #1; end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      dev_rd0 = $urandom;
      dev_rd1 = $urandom;
      cpu_kill = ($urandom_range(0, 7) == 0);
      if (!cpu_req || e_cdone) begin
        cpu_req = ($urandom_range(0, 2) != 0);
        cpu_we = $urandom_range(0, 1); cpu_addr = rnd_addr(); cpu_wdata = $urandom;
      end
      if (!dma_req || e_ddone) begin
        dma_req = ($urandom_range(0, 2) != 0);
        dma_we = $urandom_range(0, 1); dma_addr = rnd_addr(); dma_wdata = $urandom;
      end
    end
    cpu_req = 0; dma_req = 0; cpu_kill = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
